// File: rtl/sad_pkg.sv
// Shared widths for the accumulating SAD engine.
package sad_pkg;
  localparam int SAD_IN_W  = 8;
  localparam int SAD_ACC_W = 33;
  localparam int SAD_SUM_W = SAD_IN_W + 2;
endpackage

// File: rtl/sad_absdiff.sv
// Unsigned absolute difference of two operands, purely combinational.
module sad_absdiff #(
  parameter int INPUT_WIDTH = 8
) (
  input  logic [INPUT_WIDTH-1:0] x,
  input  logic [INPUT_WIDTH-1:0] y,
  output logic [INPUT_WIDTH-1:0] d
);
  assign d = (x >= y) ? x - y : y - x;
endmodule

// File: rtl/sad.sv
// Accumulating sum-of-absolute-differences over three operand pairs.
module sad
  import sad_pkg::*;
#(
  parameter int INPUT_WIDTH  = SAD_IN_W,
  parameter int OUTPUT_WIDTH = SAD_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUT_WIDTH-1:0]  a,
  input  logic [INPUT_WIDTH-1:0]  b,
  input  logic [INPUT_WIDTH-1:0]  c,
  input  logic [INPUT_WIDTH-1:0]  d,
  input  logic [INPUT_WIDTH-1:0]  e,
  input  logic [INPUT_WIDTH-1:0]  f,
  output logic [OUTPUT_WIDTH-1:0] out
);
  localparam int SW = INPUT_WIDTH + 2;

  logic [INPUT_WIDTH-1:0] d0;
  logic [INPUT_WIDTH-1:0] d1;
  logic [INPUT_WIDTH-1:0] d2;
  logic [SW-1:0]          s;
  logic [OUTPUT_WIDTH-1:0] acc;

  sad_absdiff #(.INPUT_WIDTH(INPUT_WIDTH)) u_ad0 (
    .x(a), .y(b), .d(d0)
  );
  sad_absdiff #(.INPUT_WIDTH(INPUT_WIDTH)) u_ad1 (
    .x(c), .y(d), .d(d1)
  );
  sad_absdiff #(.INPUT_WIDTH(INPUT_WIDTH)) u_ad2 (
    .x(e), .y(f), .d(d2)
  );

  // Two guard bits make the three-term sum overflow-free.
  assign s = SW'(d0) + SW'(d1) + SW'(d2);

  always_ff @(posedge clk) begin
    if (!rst) acc <= '0;
    else      acc <= acc + OUTPUT_WIDTH'(s);
  end

  assign out = acc;
endmodule

// File: tb/tb_sad.sv
// Directed and model-checked bench for the SAD accumulator.
module tb_sad;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  a = '0, b = '0, c = '0, d = '0, e = '0, f = '0;
  logic [32:0] out;
  logic [9:0]  out10;

  int nchecks = 0;
  int nerrors = 0;

  logic [32:0] exp33;
  logic [9:0]  exp10;

  always #5 clk = ~clk;

  sad u_dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .out(out)
  );

  sad #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(10)) u_dut10 (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .out(out10)
  );

  task automatic chk(input string tag, input logic [32:0] got,
                     input logic [32:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input logic [7:0] va, vb, vc, vd, ve, vf);
    a = va; b = vb; c = vc; d = vd; e = ve; f = vf;
  endtask

  function automatic int absd(input int x, input int y);
    int t;
    t = x - y;
    return (t < 0) ? -t : t;
  endfunction

  initial begin
    // reset with random operands
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      setv($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      step();
      chk("reset", out, 33'd0);
      chk("reset10", 33'(out10), 33'd0);
    end
    rst = 1'b1;
    setv(0, 0, 0, 0, 0, 0);
    step();
    chk("release_zero", out, 33'd0);

    // single step then hold
    setv(10, 3, 3, 10, 200, 200);
    step();
    chk("single", out, 33'd14);
    setv(0, 0, 0, 0, 0, 0);
    step();
    chk("hold", out, 33'd14);
    chk("hold10", 33'(out10), 33'd14);

    rst = 1'b0;
    step();
    chk("reset2", out, 33'd0);
    rst = 1'b1;

    // max terms; 10-bit copy wraps mod 1024
    setv(255, 0, 0, 255, 255, 0);
    step(); chk("max1", out, 33'd765);
    chk("w10_1", 33'(out10), 33'd765);
    step(); chk("max2", out, 33'd1530);
    chk("w10_2", 33'(out10), 33'd506);
    step(); chk("max3", out, 33'd2295);
    chk("w10_3", 33'(out10), 33'd247);
    step(); chk("max4", out, 33'd3060);
    chk("w10_4", 33'(out10), 33'd1012);

    // mid-run reset with live operands
    rst = 1'b0;
    step();
    chk("midreset", out, 33'd0);
    rst = 1'b1;
    setv(1, 0, 0, 0, 0, 0);
    step();
    chk("restart", out, 33'd1);
    chk("restart10", 33'(out10), 33'd1);

    // random run against a golden model
    exp33 = 33'd1;
    exp10 = 10'd1;
    for (int i = 0; i < 1000; i++) begin
      int s;
      setv($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      s = absd(a, b) + absd(c, d) + absd(e, f);
      exp33 = exp33 + 33'(s);
      exp10 = exp10 + 10'(s);
      step();
      chk("rand", out, exp33);
      chk("rand10", 33'(out10), 33'(exp10));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end
endmodule
